i2c_slave_rx: RTL and testbench
===============================

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit target address this block acknowledges.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on scl and sda_in (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port scl, input, 1 bit: I2C clock line, asynchronous to clk.
REQ-006 SHALL have port sda_in, input, 1 bit: I2C data line as read back from the pad, asynchronous to clk.
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 means pull SDA low (open-drain); 0 means release the line.
REQ-008 SHALL have port rx_data, output, 8 bits: last received data byte.
REQ-009 SHALL have port rx_valid, output, 1 bit: one-clk pulse, rx_data updated this cycle.
REQ-010 SHALL have port addressed, output, 1 bit: high while a write transfer to SLAVE_ADDR is in progress.
REQ-011 SHALL have port stop_det, output, 1 bit: one-clk pulse on every detected STOP.

Function
REQ-012 SHALL pass scl and sda_in through SYNC_STAGES flops, then one history flop; all edge detection SHALL use the synchronized value and the history value only.
REQ-013 SHALL detect a START when synchronized sda falls while synchronized scl is 1, and a STOP when synchronized sda rises while synchronized scl is 1.
REQ-014 SHALL have states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK and IGNORE, held in one state register.
REQ-015 SHALL enter ADDR from any state on a START (this includes a repeated START), clearing the bit counter and shift register and setting sda_oe to 0.
REQ-016 SHALL enter IDLE from any state on a STOP, setting sda_oe to 0, addressed to 0 and pulsing stop_det.
REQ-017 SHALL give START/STOP priority over any SCL edge detected in the same clk cycle.
REQ-018 SHALL shift sda into an 8-bit register MSB-first on each SCL rising edge in ADDR and DATA, with a 3-bit counter that wraps from 7 to 0.
REQ-019 SHALL, on the 8th rising edge in ADDR, go to ADDR_ACK if bits[7:1] equal SLAVE_ADDR and bit0 equals 0; otherwise it SHALL go to IGNORE.
REQ-020 SHALL, on the 8th rising edge in DATA, load rx_data, pulse rx_valid for exactly one clk and go to DATA_ACK.
REQ-021 SHALL, in ADDR_ACK and DATA_ACK, set sda_oe to 1 on the first SCL falling edge, hold it through the next rising edge, then set sda_oe to 0 on the following falling edge and enter DATA.
REQ-022 SHALL set addressed to 1 on entry to ADDR_ACK and keep it at 1 until a STOP, a START or reset.
REQ-023 SHALL, in IGNORE and IDLE, never set sda_oe to 1 and ignore SCL edges; IGNORE SHALL exit only on START or STOP.
REQ-024 SHALL have a latency from a pin change to the internal event of SYNC_STAGES+1 clk cycles; the bench SHALL hold each SCL phase for at least 4 clk.
REQ-025 SHALL NOT assert rx_valid for a partial byte cut short by a START or STOP; rx_data SHALL keep its previous value.

Reset
REQ-026 SHALL, while reset is 1 at a clk edge, set state to IDLE, the synchronizer and history flops to 1, and sda_oe, rx_valid, addressed and stop_det to 0, rx_data to 8'h00, and the counter to 0.
REQ-027 SHALL leave the first cycle after reset without any false START or STOP, even if the lines are 1 then.
REQ-028 SHALL let reset in the middle of a transfer release SDA (sda_oe set to 0) on the next clk edge, and the block SHALL wait for a new START.

Verification
REQ-029 Write to 0x50 with data 0xA5 then STOP -> ACK driven for the address and for the data, rx_valid pulses once with rx_data equal to 8'hA5, stop_det pulses once, addressed returns to 0.
REQ-030 Address 0x51 write, or 0x50 with the R/W bit set -> no ACK, sda_oe stays 0, no rx_valid, state is IGNORE until STOP.
REQ-031 Three data bytes 0x00, 0xFF and 0x3C -> three rx_valid pulses carrying those values in order, with the counter wrapping each time.
REQ-032 Repeated START after 4 data bits, then address 0x50 and data 0x12 -> no rx_valid for the partial byte, then rx_data equal to 8'h12.
REQ-033 Reset asserted during the ACK clock -> sda_oe is 0 on the next clk, state is IDLE, and a later valid transfer is received correctly.
REQ-034 START and an SCL edge landing in the same clk cycle -> START handled, no bit shifted in.

Source files
------------

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: receives an address byte and data bytes, ACKs its own address
// and every data byte, and reports each completed byte with a one-clk rx_valid pulse.
module i2c_slave_rx #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addressed,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StData, StDataAck, StIgnore
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;
  logic                   start_det, stop_ev, scl_rise, scl_fall;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addressed_q, addressed_d;
  logic       stop_det_q, stop_det_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ack_drive_q, ack_drive_d;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Bus conditions are judged only from the last sync stage against its history flop.
  assign start_det = scl_s & sda_hist_q & ~sda_s;
  assign stop_ev   = scl_s & ~sda_hist_q & sda_s;
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    addressed_d = addressed_q;
    stop_det_d  = 1'b0;
    sda_oe_d    = sda_oe_q;
    ack_drive_d = ack_drive_q;

    if (stop_ev) begin
      state_d     = StIdle;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      stop_det_d  = 1'b1;
      ack_drive_d = 1'b0;
    end else if (start_det) begin
      state_d     = StAddr;
      cnt_d       = 3'd0;
      shift_d     = 8'h00;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      ack_drive_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StData: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == StData) begin
                rx_data_d  = shift_d;
                rx_valid_d = 1'b1;
                state_d    = StDataAck;
              end else if (shift_d[7:1] == SLAVE_ADDR && !shift_d[0]) begin
                addressed_d = 1'b1;
                state_d     = StAddrAck;
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end
        StAddrAck, StDataAck: begin
          // First fall starts the ACK bit, second fall ends it.
          if (scl_fall) begin
            if (!ack_drive_q) begin
              sda_oe_d    = 1'b1;
              ack_drive_d = 1'b1;
            end else begin
              sda_oe_d    = 1'b0;
              ack_drive_d = 1'b0;
              state_d     = StData;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_hist_q  <= 1'b1;
      sda_hist_q  <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      addressed_q <= 1'b0;
      stop_det_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      ack_drive_q <= 1'b0;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_hist_q  <= scl_s;
      sda_hist_q  <= sda_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      addressed_q <= addressed_d;
      stop_det_q  <= stop_det_d;
      sda_oe_q    <= sda_oe_d;
      ack_drive_q <= ack_drive_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign addressed = addressed_q;
  assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master, table of single-byte writes, hand-built
// corner sequences, and a queue scoreboard checking every rx_valid byte.
module tb_i2c_slave_rx;

  localparam int H = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addressed;
  logic       stop_det;

  int         n_checks = 0;
  int         n_fail = 0;
  int         rv_count = 0;
  int         sd_count = 0;
  bit         oe_seen = 1'b0;
  bit         rv_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data;
    bit         ack;
    string      name;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull SDA low.
  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_rx #(
    .SLAVE_ADDR (7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .addressed(addressed),
    .stop_det (stop_det)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        rv_count++;
        if (rv_prev) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_valid_width: got pulse longer than 1 clk, expected 1 clk");
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_valid_unexpected: got data %0h, expected no rx_valid", rx_data);
        end else begin
          check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (stop_det) sd_count++;
      if (sda_oe) oe_seen = 1'b1;
    end
    rv_prev = rx_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of test, expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    tick(H);
    scl = 1'b1;
    tick(H);
    scl = 1'b0;
    tick(H);
  endtask

  task automatic ack_clock(input logic exp, input string name);
    sda_m = 1'b1;
    tick(H);
    scl = 1'b1;
    tick(H / 2);
    check(name, {31'h0, sda_oe}, {31'h0, exp});
    tick(H - H / 2);
    scl = 1'b0;
    tick(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_clock(exp_ack, name);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    tick(H);
    scl = 1'b1;
    tick(H);
    sda_m = 1'b0;
    tick(H);
    scl = 1'b0;
    tick(H);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(H);
    scl = 1'b1;
    tick(H);
    sda_m = 1'b1;
    tick(H);
  endtask

  initial begin
    int sd0, rv0;

    vecs[0] = '{addr_byte: 8'hA0, data: 8'hA5, ack: 1'b1, name: "w50_a5"};
    vecs[1] = '{addr_byte: 8'hA2, data: 8'h77, ack: 1'b0, name: "w51_nack"};
    vecs[2] = '{addr_byte: 8'hA1, data: 8'h33, ack: 1'b0, name: "r50_nack"};
    vecs[3] = '{addr_byte: 8'hA0, data: 8'h00, ack: 1'b1, name: "w50_00"};
    vecs[4] = '{addr_byte: 8'hA0, data: 8'h5A, ack: 1'b1, name: "w50_5a"};

    reset = 1'b1;
    scl   = 1'b1;
    sda_m = 1'b1;
    tick(3);
    check("reset_sda_oe", {31'h0, sda_oe}, 0);
    check("reset_rx_valid", {31'h0, rx_valid}, 0);
    check("reset_addressed", {31'h0, addressed}, 0);
    check("reset_stop_det", {31'h0, stop_det}, 0);
    check("reset_rx_data", {24'h0, rx_data}, 0);
    reset = 1'b0;
    tick(2 * H);
    check("post_reset_no_stop", sd_count, 0);
    check("post_reset_no_valid", rv_count, 0);

    for (int v = 0; v < 5; v++) begin
      sd0     = sd_count;
      rv0     = rv_count;
      oe_seen = 1'b0;
      i2c_start();
      send_byte(vecs[v].addr_byte, vecs[v].ack, {vecs[v].name, "_addr_ack"});
      check({vecs[v].name, "_addressed"}, {31'h0, addressed}, {31'h0, vecs[v].ack});
      if (vecs[v].ack) begin
        exp_q.push_back(vecs[v].data);
        last_good = vecs[v].data;
      end
      send_byte(vecs[v].data, vecs[v].ack, {vecs[v].name, "_data_ack"});
      i2c_stop();
      tick(4);
      check({vecs[v].name, "_stop_det"}, sd_count - sd0, 1);
      check({vecs[v].name, "_addressed_clr"}, {31'h0, addressed}, 0);
      check({vecs[v].name, "_rv_count"}, rv_count - rv0, vecs[v].ack ? 1 : 0);
      check({vecs[v].name, "_rx_data_hold"}, {24'h0, rx_data}, {24'h0, last_good});
      if (!vecs[v].ack) check({vecs[v].name, "_oe_never"}, {31'h0, oe_seen}, 0);
    end

    // Three bytes in one transfer: counter must wrap cleanly between bytes.
    rv0 = rv_count;
    i2c_start();
    send_byte(8'hA0, 1'b1, "multi_addr_ack");
    exp_q.push_back(8'h00);
    send_byte(8'h00, 1'b1, "multi_b0_ack");
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1, "multi_b1_ack");
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, "multi_b2_ack");
    last_good = 8'h3C;
    i2c_stop();
    tick(4);
    check("multi_rv_count", rv_count - rv0, 3);
    check("multi_sb_empty", exp_q.size(), 0);

    // Repeated START after four data bits: partial byte must be dropped.
    rv0 = rv_count;
    i2c_start();
    send_byte(8'hA0, 1'b1, "rs_addr_ack");
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    i2c_start();
    check("rs_partial_no_valid", rv_count - rv0, 0);
    check("rs_partial_rx_data", {24'h0, rx_data}, {24'h0, last_good});
    check("rs_addressed_clr", {31'h0, addressed}, 0);
    send_byte(8'hA0, 1'b1, "rs_addr2_ack");
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, "rs_data_ack");
    last_good = 8'h12;
    i2c_stop();
    tick(4);
    check("rs_rv_count", rv_count - rv0, 1);

    // Reset during the address ACK clock.
    rv0 = rv_count;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 5 || i == 7);
    sda_m = 1'b1;
    tick(H);
    scl = 1'b1;
    tick(2);
    check("rst_ack_oe_before", {31'h0, sda_oe}, 1);
    reset = 1'b1;
    tick(1);
    check("rst_ack_oe_after", {31'h0, sda_oe}, 0);
    check("rst_ack_addressed", {31'h0, addressed}, 0);
    reset = 1'b0;
    sd0 = sd_count;
    tick(2 * H);
    check("rst_no_false_stop", sd_count - sd0, 0);
    send_byte(8'hA0, 1'b0, "rst_no_start_nack");
    check("rst_idle_addressed", {31'h0, addressed}, 0);
    i2c_start();
    send_byte(8'hA0, 1'b1, "rst_after_addr_ack");
    exp_q.push_back(8'h96);
    send_byte(8'h96, 1'b1, "rst_after_data_ack");
    i2c_stop();
    tick(4);
    check("rst_rv_count", rv_count - rv0, 1);

    // START and SCL rising edge reach the block in the same clk cycle.
    rv0 = rv_count;
    i2c_start();
    send_byte(8'hA0, 1'b1, "same_addr_ack");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    sda_m = 1'b1;
    tick(H);
    scl   = 1'b1;
    sda_m = 1'b0;
    tick(H);
    scl = 1'b0;
    tick(H);
    send_byte(8'hA0, 1'b1, "same_addr2_ack");
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1, "same_data_ack");
    i2c_stop();
    tick(4);
    check("same_rv_count", rv_count - rv0, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
